// File: rtl/ro_char_seq.sv
// Ring-oscillator characterization sequencer: enables one oscillator, settles,
// then counts synchronized rising edges of its divided output over a gate window.
module ro_char_seq #(
   parameter int unsigned N_RO       = 6,
   parameter int unsigned SEL_W      = 3,
   parameter int unsigned CNT_W      = 20,
   parameter int unsigned GATE_W     = 16,
   parameter int unsigned SETTLE_CYC = 16
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              START,
   input  logic [SEL_W-1:0]  SEL,
   input  logic [GATE_W-1:0] GATE_LEN,
   input  logic [N_RO-1:0]   RO_IN,
   output logic [N_RO-1:0]   RO_EN,
   output logic              BUSY,
   output logic              DONE,
   output logic [CNT_W-1:0]  COUNT,
   output logic              OVF,
   output logic              ERR
);

   localparam int unsigned SET_W = $clog2(SETTLE_CYC) + 1;
   localparam int unsigned TMR_W = (GATE_W > SET_W) ? GATE_W : SET_W;
   localparam logic [SEL_W:0] N_RO_V = (SEL_W+1)'(N_RO);

   typedef enum logic [1:0] {IDLE, SETTLE, GATE, REPORT} state_t;

   state_t              state;
   logic [SEL_W-1:0]    sel_q;
   logic [GATE_W-1:0]   gate_q;
   logic [TMR_W-1:0]    tmr;
   logic                s1, s2, s3;
   logic                ro_mux_c;
   logic [N_RO-1:0]     onehot_c;
   logic                ro_edge_c;
   logic                start_ok_c;

   // Select the oscillator ahead of the synchronizer; sel_q is static during a run.
   always_comb begin
      ro_mux_c = 1'b0;
      onehot_c = '0;
      for (int unsigned i = 0; i < N_RO; i++) begin
         if (sel_q == SEL_W'(i)) begin
            ro_mux_c    = RO_IN[i];
            onehot_c[i] = 1'b1;
         end
      end
   end

   assign ro_edge_c  = s2 & ~s3;
   assign start_ok_c = ({1'b0, SEL} < N_RO_V) && (GATE_LEN != '0);

   // RO_EN/BUSY/DONE are registered from the state, so they trail it by one cycle.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state  <= IDLE;
         sel_q  <= '0;
         gate_q <= '0;
         tmr    <= '0;
         s1     <= 1'b0;
         s2     <= 1'b0;
         s3     <= 1'b0;
         RO_EN  <= '0;
         BUSY   <= 1'b0;
         DONE   <= 1'b0;
         COUNT  <= '0;
         OVF    <= 1'b0;
         ERR    <= 1'b0;
      end else begin
         s1    <= ro_mux_c;
         s2    <= s1;
         s3    <= s2;
         RO_EN <= (state == SETTLE || state == GATE) ? onehot_c : '0;
         BUSY  <= (state != IDLE);
         DONE  <= (state == REPORT);

         case (state)
            IDLE: begin
               if (START) begin
                  COUNT <= '0;
                  OVF   <= 1'b0;
                  if (start_ok_c) begin
                     sel_q  <= SEL;
                     gate_q <= GATE_LEN;
                     ERR    <= 1'b0;
                     tmr    <= TMR_W'(SETTLE_CYC - 1);
                     state  <= SETTLE;
                  end else begin
                     ERR    <= 1'b1;
                     state  <= REPORT;
                  end
               end
            end
            SETTLE: begin
               if (tmr == '0) begin
                  tmr   <= TMR_W'(gate_q - GATE_W'(1));
                  state <= GATE;
               end else begin
                  tmr <= tmr - TMR_W'(1);
               end
            end
            GATE: begin
               if (ro_edge_c) begin
                  if (&COUNT) OVF <= 1'b1;
                  else        COUNT <= COUNT + CNT_W'(1);
               end
               if (tmr == '0) state <= REPORT;
               else           tmr   <= tmr - TMR_W'(1);
            end
            REPORT: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ro_char_seq.sv
// Bench for ro_char_seq: random/directed oscillator waveforms, edge counts predicted
// from a recorded per-cycle history of RO_IN.
module tb_ro_char_seq;

   localparam int SC    = 16;
   localparam int MAX_M = (1 << 20) - 1;
   localparam int MAX_S = 15;

   logic        CLK = 1'b0;
   logic        RST;
   logic        START;
   logic [2:0]  SEL;
   logic [15:0] GATE_LEN;
   logic [5:0]  RO_IN = 6'b0;
   logic [5:0]  RO_EN,  RO_EN_S;
   logic        BUSY,   BUSY_S;
   logic        DONE,   DONE_S;
   logic [19:0] COUNT;
   logic [3:0]  COUNT_S;
   logic        OVF,    OVF_S;
   logic        ERR,    ERR_S;

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;
   logic [5:0] hist [0:65535];
   int hp_fixed [6] = '{0, 0, 0, 0, 0, 0};
   int ph       [6] = '{3, 4, 5, 2, 6, 3};

   ro_char_seq dut (
      .CLK(CLK), .RST(RST), .START(START), .SEL(SEL), .GATE_LEN(GATE_LEN),
      .RO_IN(RO_IN), .RO_EN(RO_EN), .BUSY(BUSY), .DONE(DONE),
      .COUNT(COUNT), .OVF(OVF), .ERR(ERR)
   );

   ro_char_seq #(.CNT_W(4)) dut_s (
      .CLK(CLK), .RST(RST), .START(START), .SEL(SEL), .GATE_LEN(GATE_LEN),
      .RO_IN(RO_IN), .RO_EN(RO_EN_S), .BUSY(BUSY_S), .DONE(DONE_S),
      .COUNT(COUNT_S), .OVF(OVF_S), .ERR(ERR_S)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) begin
      hist[cyc] <= RO_IN;
      cyc       <= cyc + 1;
   end

   // Oscillator phases change on the falling edge and last at least 2 cycles.
   always @(negedge CLK) begin
      for (int i = 0; i < 6; i++) begin
         if (ph[i] <= 1) begin
            RO_IN[i] = ~RO_IN[i];
            ph[i]    = (hp_fixed[i] != 0) ? hp_fixed[i] : int'($urandom_range(2, 7));
         end else begin
            ph[i] = ph[i] - 1;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Rising edges of the selected input that reach the edge detector while gating.
   function automatic int model_edges(input int t, input int sel, input int g);
      int e = 0;
      for (int j = t + SC - 2; j <= t + SC + g - 3; j++)
         if (!hist[j][sel] && hist[j+1][sel]) e++;
      return e;
   endfunction

   task automatic watch_run(input int t, input int sel, input int g, input bit ok, input int poke);
      int L;
      int e;
      logic [5:0] oh;
      L  = ok ? SC + g + 1 : 1;
      oh = 6'(1 << sel);
      for (int k = t; k <= t + L; k++) begin
         if (k != t) @(negedge CLK);
         if (poke > 0 && k == t + poke) begin
            START = 1'b1; SEL = 3'd3; GATE_LEN = 16'd7;
         end
         if (poke > 0 && k == t + poke + 1) START = 1'b0;
         chk("ro_en",   32'(RO_EN),   32'((ok && k > t && k < t + L) ? oh : 6'd0));
         chk("ro_en_s", 32'(RO_EN_S), 32'((ok && k > t && k < t + L) ? oh : 6'd0));
         chk("busy",    32'(BUSY),    32'(k > t));
         chk("done",    32'(DONE),    32'(k == t + L));
         chk("done_s",  32'(DONE_S),  32'(k == t + L));
         if (k == t) begin
            chk("count_clr", 32'(COUNT), 32'd0);
            chk("err_acc",   32'(ERR),   32'(!ok));
         end
      end
      e = ok ? model_edges(t, sel, g) : 0;
      chk("count",   32'(COUNT),   32'((e > MAX_M) ? MAX_M : e));
      chk("ovf",     32'(OVF),     32'(e > MAX_M));
      chk("err",     32'(ERR),     32'(!ok));
      chk("count_s", 32'(COUNT_S), 32'((e > MAX_S) ? MAX_S : e));
      chk("ovf_s",   32'(OVF_S),   32'(e > MAX_S));
   endtask

   task automatic run_meas(input int sel, input int g, input int poke);
      bit ok;
      int t;
      ok       = (sel < 6) && (g != 0);
      START    = 1'b1;
      SEL      = 3'(sel);
      GATE_LEN = 16'(g);
      @(posedge CLK);
      @(negedge CLK);
      START = 1'b0;
      t     = cyc - 1;
      watch_run(t, sel, g, ok, poke);
   endtask

   initial begin
      int t;
      RST = 1'b1; START = 1'b0; SEL = 3'd0; GATE_LEN = 16'd0;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      chk("rst_ro_en", 32'(RO_EN), 32'd0);
      chk("rst_busy",  32'(BUSY),  32'd0);
      chk("rst_done",  32'(DONE),  32'd0);
      chk("rst_count", 32'(COUNT), 32'd0);
      chk("rst_ovf",   32'(OVF),   32'd0);
      chk("rst_err",   32'(ERR),   32'd0);
      RST = 1'b0;
      @(negedge CLK);

      // Basic count: period-8 oscillator on bit 2 over 80 cycles.
      hp_fixed[2] = 4;
      run_meas(2, 80, 0);
      chk("basic_count", 32'(COUNT), 32'd10);

      // Saturation of the narrow counter, held afterwards in IDLE.
      hp_fixed[0] = 2;
      run_meas(0, 100, 0);
      chk("sat_count", 32'(COUNT_S), 32'd15);
      chk("sat_ovf",   32'(OVF_S),   32'd1);
      repeat (5) @(negedge CLK);
      chk("sat_hold",  32'(COUNT_S), 32'd15);
      chk("sat_ovf_h", 32'(OVF_S),   32'd1);

      // Rejected starts.
      run_meas(6, 50, 0);
      run_meas(1, 0, 0);
      run_meas(7, 20, 0);

      // START/SEL/GATE_LEN pokes during GATE are ignored; bit 3 toggles fast.
      hp_fixed[3] = 2;
      run_meas(1, 60, SC + 10);

      // Reset in the middle of GATE.
      START = 1'b1; SEL = 3'd2; GATE_LEN = 16'd80;
      @(posedge CLK);
      @(negedge CLK);
      START = 1'b0;
      repeat (40) @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      chk("mrst_ro_en", 32'(RO_EN), 32'd0);
      chk("mrst_busy",  32'(BUSY),  32'd0);
      chk("mrst_count", 32'(COUNT), 32'd0);
      chk("mrst_done",  32'(DONE),  32'd0);
      for (int i = 0; i < 70; i++) begin
         @(negedge CLK);
         chk("mrst_nodone", 32'(DONE), 32'd0);
      end
      run_meas(2, 80, 0);
      chk("post_rst_count", 32'(COUNT), 32'd10);

      // Back-to-back with START held high: one run every SC+GATE_LEN+2 cycles.
      START = 1'b1; SEL = 3'd4; GATE_LEN = 16'd30;
      @(posedge CLK);
      @(negedge CLK);
      t = cyc - 1;
      for (int r = 0; r < 3; r++) begin
         watch_run(t, 4, 30, 1'b1, 0);
         @(negedge CLK);
         t = t + SC + 30 + 2;
      end
      START = 1'b0;
      repeat (SC + 33) @(negedge CLK);

      // Random runs, including invalid selects and random waveforms.
      hp_fixed = '{0, 0, 0, 0, 0, 0};
      for (int r = 0; r < 10; r++) begin
         run_meas(int'($urandom_range(0, 7)), int'($urandom_range(0, 120)), 0);
         repeat (int'($urandom_range(0, 3))) @(negedge CLK);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
